hack_alu_pipe: RTL and testbench
================================

HACK_ALU_PIPE -- requirements
Module: hack_alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width in bits, legal range 2..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: stage 1 accepts an operation this cycle.
REQ-006 SHALL have ports x and y, input, WIDTH bits each: operands.
REQ-007 SHALL have port ctrl, input, 6 bits: {zx,nx,zy,ny,f,no}, with zx at bit 5 and no at bit 0.
REQ-008 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port out, output, WIDTH bits: the result.
REQ-011 SHALL have ports zr and ng, output, 1 bit each: out==0, and out[WIDTH-1].

Function
REQ-012 SHALL compute Hack ALU semantics:
- zx zeroes x, then nx inverts x.
- zy and ny do the same for y.
- f=1 gives x+y mod 2^WIDTH; f=0 gives x&y.
- no inverts the result.
REQ-013 SHALL be a two-stage pipeline:
- stage 1 registers the preprocessed x and y together with f and no.
- stage 2 registers out, zr, ng (and cf when enabled).
REQ-014 SHALL produce a result 2 cycles after acceptance, when out_ready is held 1.
REQ-015 SHALL accept an operation only on the cycle where in_valid and in_ready are both 1.
REQ-016 SHALL deliver a result only on the cycle where out_valid and out_ready are both 1.
REQ-017 SHALL drive each stage's ready as (stage empty) OR (downstream stage ready); in_ready is stage 1's ready, combinational on out_ready.
REQ-018 SHALL hold out, zr, ng and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL hold up to 2 operations in flight; in_ready=0 when both stages are full and out_ready=0.
REQ-020 SHALL allow, with both stages full and out_ready=1, simultaneous delivery, advance and acceptance, giving full throughput of 1 op/cycle.
REQ-021 SHALL deliver results in acceptance order, never dropping or duplicating any.
REQ-022 SHALL derive zr and ng from the registered out only, never from the inputs.
REQ-023 SHALL treat data and ctrl presented while in_valid=0 as don't-care and leave state unaffected.

Reset
REQ-024 SHALL, while rst_n=0, force both stage valid bits to 0, out_valid=0, out=0, zr=0, ng=0, cf=0.
REQ-025 SHALL make in_ready=1 during reset and on the first cycle after reset release.
REQ-026 SHALL discard all in-flight operations on reset assertion mid-operation; no partial result appears after release.

Configuration
REQ-027 SHALL, when macro HACK_ALU_CARRY_EN is defined, add output port cf (1 bit): carry-out of the WIDTH-bit add when f=1, 0 when f=0, unaffected by no, pipelined alongside out.
REQ-028 SHALL, without HACK_ALU_CARRY_EN, omit cf and its register entirely, with otherwise identical behaviour.

Structure
REQ-029 SHALL take from shared package hack_alu_pkg:
- ctrl bit-index constants (CTRL_ZX=5 .. CTRL_NO=0).
- a 6-bit ctrl typedef.
- named opcode constants for the 18 Hack operations.
REQ-030 SHALL instantiate one combinational sub-module, hack_alu_core (WIDTH-parametrised, ctrl in, out/zr/ng/cf out); the pipeline registers and handshake stay in hack_alu_pipe.

Verification
REQ-031 SHALL cover: WIDTH=16, x=0x0011, y=0x0003, all 18 Hack opcodes streamed back-to-back, out_ready=1 -> results match golden values (e.g. x+y=0x0014, x-y=0x000E, y-x=0xFFF2 with ng=1), each 2 cycles after acceptance, 1 per cycle.
REQ-032 SHALL cover: ctrl=101010 (constant 0) -> out=0x0000, zr=1, ng=0; ctrl=111010 (constant -1) -> out=0xFFFF, zr=0, ng=1.
REQ-033 SHALL cover: out_ready=0 while 3 ops are offered -> 2 accepted, in_ready=0 on the 3rd, out stable; out_ready=1 -> all 3 delivered in order, none lost.
REQ-034 SHALL cover: rst_n pulsed low with 2 ops in flight -> out_valid=0 immediately, no result after release, in_ready=1.
REQ-035 SHALL cover, with HACK_ALU_CARRY_EN: x=0xFFFF, y=0x0001, ctrl=000010 -> out=0x0000, zr=1, cf=1; ctrl=000000 -> cf=0.
REQ-036 SHALL cover: WIDTH=8, x=0x7F, y=0x01, ctrl=000010 -> out=0x80, ng=1, zr=0.

Source files
------------

// File: rtl/hack_alu_pkg.sv
// Shared Hack ALU definitions: ctrl bit positions, ctrl type and the 18 standard opcodes.
package hack_alu_pkg;

  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  typedef logic [5:0] ctrl_t;

  localparam ctrl_t OP_ZERO  = 6'b101010;
  localparam ctrl_t OP_ONE   = 6'b111111;
  localparam ctrl_t OP_NEG1  = 6'b111010;
  localparam ctrl_t OP_X     = 6'b001100;
  localparam ctrl_t OP_Y     = 6'b110000;
  localparam ctrl_t OP_NOTX  = 6'b001101;
  localparam ctrl_t OP_NOTY  = 6'b110001;
  localparam ctrl_t OP_NEGX  = 6'b001111;
  localparam ctrl_t OP_NEGY  = 6'b110011;
  localparam ctrl_t OP_XINC  = 6'b011111;
  localparam ctrl_t OP_YINC  = 6'b110111;
  localparam ctrl_t OP_XDEC  = 6'b001110;
  localparam ctrl_t OP_YDEC  = 6'b110010;
  localparam ctrl_t OP_XADDY = 6'b000010;
  localparam ctrl_t OP_XSUBY = 6'b010011;
  localparam ctrl_t OP_YSUBX = 6'b000111;
  localparam ctrl_t OP_XANDY = 6'b000000;
  localparam ctrl_t OP_XORY  = 6'b010101;

endpackage

// File: rtl/hack_alu_core.sv
// Combinational Hack ALU. The cf output exists only when HACK_ALU_CARRY_EN is defined.
module hack_alu_core
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  ctrl_t            ctrl,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
`ifdef HACK_ALU_CARRY_EN
  ,
  output logic             cf
`endif
);

  logic [WIDTH-1:0] xz, xp, yz, yp, fres;
`ifdef HACK_ALU_CARRY_EN
  logic [WIDTH:0]   sum;
`else
  logic [WIDTH-1:0] sum;
`endif

  always_comb begin
    xz   = ctrl[CTRL_ZX] ? '0 : x;
    xp   = ctrl[CTRL_NX] ? ~xz : xz;
    yz   = ctrl[CTRL_ZY] ? '0 : y;
    yp   = ctrl[CTRL_NY] ? ~yz : yz;
`ifdef HACK_ALU_CARRY_EN
    sum  = {1'b0, xp} + {1'b0, yp};
    fres = ctrl[CTRL_F] ? sum[WIDTH-1:0] : (xp & yp);
    cf   = ctrl[CTRL_F] & sum[WIDTH];
`else
    sum  = xp + yp;
    fres = ctrl[CTRL_F] ? sum : (xp & yp);
`endif
    out  = ctrl[CTRL_NO] ? ~fres : fres;
    zr   = (out == '0);
    ng   = out[WIDTH-1];
  end

endmodule

// File: rtl/hack_alu_pipe.sv
// Two-stage valid/ready pipelined Hack ALU. Define HACK_ALU_CARRY_EN to add the cf output.
module hack_alu_pipe
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  ctrl_t            ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
`ifdef HACK_ALU_CARRY_EN
  ,
  output logic             cf
`endif
);

  logic             s1_valid, s2_valid, s1_ready, s2_ready;
  logic [WIDTH-1:0] pre_x, pre_y, s1_x, s1_y;
  logic             s1_f, s1_no;
  logic [WIDTH-1:0] core_out;
  logic             core_zr, core_ng;
`ifdef HACK_ALU_CARRY_EN
  logic             core_cf;
`endif

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid;

  always_comb begin
    pre_x = ctrl[CTRL_ZX] ? '0 : x;
    pre_x = ctrl[CTRL_NX] ? ~pre_x : pre_x;
    pre_y = ctrl[CTRL_ZY] ? '0 : y;
    pre_y = ctrl[CTRL_NY] ? ~pre_y : pre_y;
  end

  // Operands are already preprocessed, so the core only sees f and no.
  hack_alu_core #(.WIDTH(WIDTH)) u_core (
    .x    (s1_x),
    .y    (s1_y),
    .ctrl ({4'b0000, s1_f, s1_no}),
    .out  (core_out),
    .zr   (core_zr),
    .ng   (core_ng)
`ifdef HACK_ALU_CARRY_EN
    ,
    .cf   (core_cf)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_f     <= 1'b0;
      s1_no    <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x  <= pre_x;
        s1_y  <= pre_y;
        s1_f  <= ctrl[CTRL_F];
        s1_no <= ctrl[CTRL_NO];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out      <= '0;
      zr       <= 1'b0;
      ng       <= 1'b0;
`ifdef HACK_ALU_CARRY_EN
      cf       <= 1'b0;
`endif
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out <= core_out;
        zr  <= core_zr;
        ng  <= core_ng;
`ifdef HACK_ALU_CARRY_EN
        cf  <= core_cf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Scoreboard bench for hack_alu_pipe (WIDTH=16 and WIDTH=8 instances); honours HACK_ALU_CARRY_EN.
module tb_hack_alu_pipe;
  import hack_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, zr, ng;
  logic [15:0] x = '0, y = '0, out;
  ctrl_t       ctrl = '0;
`ifdef HACK_ALU_CARRY_EN
  logic        cf, cf8;
`endif

  logic        iv8 = 1'b0, or8 = 1'b1;
  logic        ir8, ov8, zr8, ng8;
  logic [7:0]  x8 = '0, y8 = '0, o8;
  ctrl_t       c8 = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [15:0] o;
    logic        zr;
    logic        ng;
    logic        cf;
    int          acc;
    bit          lat;
  } exp_t;
  exp_t q[$];

  typedef struct {
    ctrl_t       c;
    logic [15:0] o;
    logic        zr;
    logic        ng;
    logic        cf;
  } vec_t;
  vec_t tbl[18];

  hack_alu_pipe #(.WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng)
`ifdef HACK_ALU_CARRY_EN
    , .cf(cf)
`endif
  );

  hack_alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .x(x8), .y(y8), .ctrl(c8), .out_valid(ov8), .out_ready(or8),
    .out(o8), .zr(zr8), .ng(ng8)
`ifdef HACK_ALU_CARRY_EN
    , .cf(cf8)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit rdy, input logic [15:0] a, input logic [15:0] b,
                               input ctrl_t c, input logic [15:0] eo, input logic ezr, input logic eng,
                               input logic ecf, input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    out_ready = rdy;
    x         = a;
    y         = b;
    ctrl      = c;
    #1;
    acc = v && in_ready;
    if (acc) begin
      e.o = eo; e.zr = ezr; e.ng = eng; e.cf = ecf; e.acc = cyc; e.lat = lat;
      q.push_back(e);
    end
  endtask

  task automatic idle(input bit rdy);
    bit acc;
    applyStimulus(1'b0, rdy, 16'hDEAD, 16'hBEEF, 6'b110101, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  // Monitor: pops on every delivery and checks that a stalled output holds still.
  initial begin
    bit          held = 1'b0;
    logic [15:0] hout = '0;
    logic        hzr = 1'b0, hng = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en || !rst_n) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_out", 64'(out), 64'(hout));
        checkOutput("hold_flags", 64'({zr, ng}), 64'({hzr, hng}));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_result: got out=0x%0h with nothing outstanding (cycle %0d)", out, cyc);
        end else begin
          e = q.pop_front();
          checkOutput("out", 64'(out), 64'(e.o));
          checkOutput("zr", 64'(zr), 64'(e.zr));
          checkOutput("ng", 64'(ng), 64'(e.ng));
`ifdef HACK_ALU_CARRY_EN
          checkOutput("cf", 64'(cf), 64'(e.cf));
`endif
          if (e.lat) checkOutput("latency", 64'(cyc - e.acc), 64'd2);
        end
      end
      held = out_valid && !out_ready;
      hout = out;
      hzr  = zr;
      hng  = ng;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int n;

    tbl[0]  = '{OP_ZERO,  16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{OP_ONE,   16'h0001, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{OP_NEG1,  16'hFFFF, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{OP_X,     16'h0011, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{OP_Y,     16'h0003, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{OP_NOTX,  16'hFFEE, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{OP_NOTY,  16'hFFFC, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{OP_NEGX,  16'hFFEF, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{OP_NEGY,  16'hFFFD, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{OP_XINC,  16'h0012, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{OP_YINC,  16'h0004, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{OP_XDEC,  16'h0010, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{OP_YDEC,  16'h0002, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{OP_XADDY, 16'h0014, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{OP_XSUBY, 16'h000E, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{OP_YSUBX, 16'hFFF2, 1'b0, 1'b1, 1'b1};
    tbl[16] = '{OP_XANDY, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{OP_XORY,  16'h0013, 1'b0, 1'b0, 1'b0};

    // Reset state
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out", 64'(out), 64'd0);
    checkOutput("rst_flags", 64'({zr, ng}), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef HACK_ALU_CARRY_EN
    checkOutput("rst_cf", 64'(cf), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

    // All 18 opcodes back-to-back, then the carry boundary vectors
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, 1'b1, 16'h0011, 16'h0003, tbl[i].c, tbl[i].o, tbl[i].zr, tbl[i].ng,
                    tbl[i].cf, 1'b1, acc);
      checkOutput("stream_accept", 64'(acc), 64'd1);
    end
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'h0001, OP_XADDY, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, acc);
    checkOutput("carry_add_accept", 64'(acc), 64'd1);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'h0001, OP_XANDY, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    checkOutput("carry_and_accept", 64'(acc), 64'd1);
    n = 0;
    while (q.size() != 0 && n < 10) begin
      idle(1'b1);
      n++;
    end
    checkOutput("stream_drain", 64'(q.size()), 64'd0);

    // Backpressure: two fit, the third waits until the consumer is ready
    applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0003, OP_XADDY, 16'h0014, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    checkOutput("bp_accept_1", 64'(acc), 64'd1);
    applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0003, OP_XSUBY, 16'h000E, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    checkOutput("bp_accept_2", 64'(acc), 64'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0003, OP_XANDY, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    n = 0;
    acc = 1'b0;
    while (!acc && n < 5) begin
      applyStimulus(1'b1, 1'b1, 16'h0011, 16'h0003, OP_XANDY, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      n++;
    end
    checkOutput("bp_accept_3", 64'(acc), 64'd1);
    n = 0;
    while (q.size() != 0 && n < 10) begin
      idle(1'b1);
      n++;
    end
    checkOutput("bp_drain", 64'(q.size()), 64'd0);

    // Reset with two operations in flight
    applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0003, OP_X, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0003, OP_Y, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_release_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) idle(1'b1);
    checkOutput("midrst_no_result", 64'(out_valid), 64'd0);

    // WIDTH=8 sign boundary
    @(negedge clk);
    iv8 = 1'b1; x8 = 8'h7F; y8 = 8'h01; c8 = OP_XADDY;
    #1;
    checkOutput("w8_accept", 64'(ir8), 64'd1);
    @(negedge clk);
    iv8 = 1'b0;
    #1;
    n = 0;
    while (!ov8 && n < 5) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("w8_valid", 64'(ov8), 64'd1);
    checkOutput("w8_out", 64'(o8), 64'h80);
    checkOutput("w8_ng", 64'(ng8), 64'd1);
    checkOutput("w8_zr", 64'(zr8), 64'd0);
`ifdef HACK_ALU_CARRY_EN
    checkOutput("w8_cf", 64'(cf8), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
